// File: rtl/dram_port.sv
// dram_port: data-RAM responder with 1-entry write-post and read merge.
// Build option DRAM_CLEAR_EN: zero the array during INIT.
module dram_port #(
  parameter int              XLEN      = 32,
  parameter int              ADDR_W    = 10,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h0001_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] dram_rd_addr_i,
  input  logic [XLEN-1:0] dram_wr_addr_i,
  input  logic [XLEN-1:0] dram_wr_data_i,
  input  logic [3:0]      dram_wr_byte_en_i,
  output logic [XLEN-1:0] dram_rd_data_o,
  output logic            dram_fault_o,
  output logic            dram_ready_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int HI    = ADDR_W + 2;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic              ready;
  logic [XLEN-1:0]   mem [DEPTH];

  logic              pend_vld;
  logic [ADDR_W-1:0] pend_idx;
  logic [XLEN-1:0]   pend_data;
  logic [3:0]        pend_be;

  logic [XLEN-1:0]   rd_data;
  logic              fault;

  logic              rd_in;
  logic              wr_in;
  logic              wr_req;
  logic              wr_ok;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic [XLEN-1:0]   merged;
  logic              unused_bits;

`ifdef DRAM_CLEAR_EN
  logic [ADDR_W-1:0] cnt;
  logic              clr_we;
  assign clr_we = (state == INIT) && !rst_i;
`endif

  assign rd_in  = dram_rd_addr_i[XLEN-1:HI] == BASE_ADDR[XLEN-1:HI];
  assign wr_in  = dram_wr_addr_i[XLEN-1:HI] == BASE_ADDR[XLEN-1:HI];
  assign rd_idx = dram_rd_addr_i[HI-1:2];
  assign wr_idx = dram_wr_addr_i[HI-1:2];
  assign wr_req = ready && (dram_wr_byte_en_i != 4'b0000);
  assign wr_ok  = wr_req && wr_in;

  assign unused_bits = ^{dram_rd_addr_i[1:0], dram_wr_addr_i[1:0]};

  // Sequencer: INIT (optionally walking the clear counter) then RUN.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= INIT;
      ready <= 1'b0;
`ifdef DRAM_CLEAR_EN
      cnt   <= '0;
`endif
    end else begin
      unique case (state)
        INIT: begin
`ifdef DRAM_CLEAR_EN
          if (cnt == '1) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`else
          state <= RUN;
          ready <= 1'b1;
`endif
        end
        RUN: ready <= 1'b1;
      endcase
    end
  end

  // Array write port: clear walk, else commit of the posted write.
  always_ff @(posedge clk_i) begin
`ifdef DRAM_CLEAR_EN
    if (clr_we) begin
      mem[cnt] <= '0;
    end else
`endif
    if (pend_vld && !rst_i) begin
      for (int k = 0; k < 4; k++) begin
        if (pend_be[k]) mem[pend_idx][8*k +: 8] <= pend_data[8*k +: 8];
      end
    end
  end

  // Read merge: array word, overlaid by pending lanes, then live write lanes.
  always_comb begin
    merged = mem[rd_idx];
    for (int k = 0; k < 4; k++) begin
      if (pend_vld && pend_idx == rd_idx && pend_be[k])
        merged[8*k +: 8] = pend_data[8*k +: 8];
      if (wr_ok && wr_idx == rd_idx && dram_wr_byte_en_i[k])
        merged[8*k +: 8] = dram_wr_data_i[8*k +: 8];
    end
  end

  // Registered read data, write-post capture and sticky fault.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data  <= '0;
      fault    <= 1'b0;
      pend_vld <= 1'b0;
    end else begin
      rd_data  <= (ready && rd_in) ? merged : '0;
      pend_vld <= wr_ok;
      if (wr_ok) begin
        pend_idx  <= wr_idx;
        pend_data <= dram_wr_data_i;
        pend_be   <= dram_wr_byte_en_i;
      end
      if (ready && (!rd_in || (wr_req && !wr_in))) fault <= 1'b1;
    end
  end

  assign dram_rd_data_o = rd_data;
  assign dram_fault_o   = fault;
  assign dram_ready_o   = ready;

endmodule

// File: tb/tb_dram_port.sv
// tb_dram_port: directed checks of dram_port read/write/merge/fault paths.
// Honours DRAM_CLEAR_EN for the init length and post-reset contents.
module tb_dram_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd_addr;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  be;
  logic [31:0] rd_data;
  logic        fault;
  logic        ready;

  int checks = 0;
  int errors = 0;
  int n;

`ifdef DRAM_CLEAR_EN
  localparam int INIT_CYC = 1024;
  localparam logic [31:0] POST_RST_40 = 32'h0000_0000;
`else
  localparam int INIT_CYC = 1;
  localparam logic [31:0] POST_RST_40 = 32'h1234_5678;
`endif

  dram_port dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .dram_rd_addr_i    (rd_addr),
    .dram_wr_addr_i    (wr_addr),
    .dram_wr_data_i    (wr_data),
    .dram_wr_byte_en_i (be),
    .dram_rd_data_o    (rd_data),
    .dram_fault_o      (fault),
    .dram_ready_o      (ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] b);
    wr_addr = a;
    wr_data = d;
    be      = b;
  endtask

  initial begin
    rst     = 1'b1;
    rd_addr = 32'h0001_0000;
    wr(32'h0001_0000, 32'h0, 4'b0000);
    tick();
    tick();
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_rdata", rd_data, 32'h0);

    // 1: init length; a write during INIT is dropped
    rst = 1'b0;
    wr(32'h0001_0040, 32'hBADB_AD00, 4'b1111);
    tick();
    be = 4'b0000;
    n = 1;
    while (!ready && n < 3000) begin
      tick();
      n++;
    end
    chk("init_cycles", n, INIT_CYC);
`ifdef DRAM_CLEAR_EN
    rd_addr = 32'h0001_0FFC;
    tick();
    chk("clear_top", rd_data, 32'h0);
`endif

    // 2: pend merge before commit, then committed value
    wr(32'h0001_0010, 32'hDEAD_BEEF, 4'b1111);
    tick();
    be = 4'b0000;
    rd_addr = 32'h0001_0010;
    tick();
    chk("pend_merge", rd_data, 32'hDEAD_BEEF);
    tick();
    chk("committed", rd_data, 32'hDEAD_BEEF);

    // 3: same-cycle lane override
    wr(32'h0001_0020, 32'h1122_3344, 4'b1111);
    tick();
    wr(32'h0001_0020, 32'h00AA_0000, 4'b0100);
    rd_addr = 32'h0001_0020;
    tick();
    chk("same_cyc", rd_data, 32'h11AA_3344);
    be = 4'b0000;
    tick();
    chk("same_cyc_pend", rd_data, 32'h11AA_3344);
    tick();
    chk("same_cyc_mem", rd_data, 32'h11AA_3344);

    // 4: back-to-back partial writes
    wr(32'h0001_0030, 32'h0, 4'b1111);
    tick();
    wr(32'h0001_0031, 32'h0000_0055, 4'b0001);
    tick();
    wr(32'h0001_0030, 32'h6600_0000, 4'b1000);
    tick();
    be = 4'b0000;
    tick();
    tick();
    rd_addr = 32'h0001_0030;
    tick();
    chk("b2b", rd_data, 32'h6600_0055);
    chk("no_fault", {31'b0, fault}, 32'd0);

    // 5: out-of-window read and write
    rd_addr = 32'h0002_0000;
    tick();
    chk("oow_rd_data", rd_data, 32'h0);
    chk("oow_fault", {31'b0, fault}, 32'd1);
    rd_addr = 32'h0001_0030;
    tick();
    chk("after_oow", rd_data, 32'h6600_0055);
    wr(32'h0000_0030, 32'hFFFF_FFFF, 4'b1111);
    tick();
    chk("oow_wr_live", rd_data, 32'h6600_0055);
    be = 4'b0000;
    tick();
    tick();
    chk("oow_wr_drop", rd_data, 32'h6600_0055);
    chk("fault_sticky", {31'b0, fault}, 32'd1);

    // 6: reset discards the posted write
    wr(32'h0001_0040, 32'h1234_5678, 4'b1111);
    tick();
    be = 4'b0000;
    tick();
    wr(32'h0001_0040, 32'hCAFE_F00D, 4'b1111);
    tick();
    rst = 1'b1;
    be  = 4'b0000;
    rd_addr = 32'h0001_0040;
    tick();
    chk("rst2_fault", {31'b0, fault}, 32'd0);
    chk("rst2_ready", {31'b0, ready}, 32'd0);
    chk("rst2_rdata", rd_data, 32'h0);
    rst = 1'b0;
    n = 0;
    while (!ready && n < 3000) begin
      tick();
      n++;
    end
    chk("init2_cycles", n, INIT_CYC);
    tick();
    chk("rst_drop_pend", rd_data, POST_RST_40);
    chk("fault_clear", {31'b0, fault}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
